// File: rtl/vga_vram_write_scheduler.sv
`timescale 1ns/1ps
// vga_vram_write_scheduler
// Buffers CPU word writes destined for a 320-pixel-wide VRAM line and releases
// them to the VRAM write port only while the selected display-timing gate is
// open. This keeps CPU updates from tearing the visible picture. The queue is a
// small power-of-two FIFO, and at most one VRAM word is written per cycle.
module vga_vram_write_scheduler #(
  parameter int DEPTH = 4,   // queue entries, power of two, 2..16
  parameter int WORDS = 10   // 32-bit VRAM words per line (320 / 32)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_word,
  input  logic [31:0] req_data,
  input  logic [1:0]  mode,
  input  logic        blank,
  input  logic        vblank,
  input  logic        flush,
  input  logic        clear_status,
  output logic        vram_we,
  output logic [3:0]  vram_word,
  output logic [31:0] vram_data,
  output logic [4:0]  level,
  output logic        overflow,
  output logic        bad_addr,
  output logic        idle
);

  localparam int         AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0] LP_DEPTH = 5'(DEPTH);
  localparam logic [4:0] LP_WORDS = 5'(WORDS);

  // Drain gate selection, encoded exactly as the mode input.
  typedef enum logic [1:0] {
    MODE_IMMEDIATE = 2'b00,
    MODE_ANY_BLANK = 2'b01,
    MODE_VBLANK    = 2'b10,
    MODE_HOLD      = 2'b11
  } drain_mode_t;

  // The scheduler is IDLE when empty. When non-empty it is WAIT if the gate is
  // closed and DRAIN if the gate is open.
  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_WAIT  = 2'b01,
    S_DRAIN = 2'b10
  } state_t;

  typedef struct packed {
    logic [3:0]  word;
    logic [31:0] data;
  } entry_t;

  // Registered state
  entry_t        r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [4:0]    r_level;
  state_t        r_state;
  logic          r_run;        // low through reset and for the first cycle after release
  logic          r_vram_we;
  logic [3:0]    r_vram_word;
  logic [31:0]   r_vram_data;
  logic          r_overflow;
  logic          r_bad_addr;

  // Combinational decode
  drain_mode_t   w_mode;
  logic          w_gate;
  logic          w_in_range;
  logic          w_accept;
  logic          w_push;
  logic          w_pop;
  logic [4:0]    w_level_nxt;
  state_t        w_state_nxt;

  assign w_mode     = drain_mode_t'(mode);
  assign w_in_range = ({1'b0, req_word} < LP_WORDS);

  // Readiness depends only on registered occupancy plus the flush request.
  // A full queue refuses the request even if an entry pops in the same cycle.
  assign req_ready  = r_run && (r_level != LP_DEPTH) && !flush;
  assign w_accept   = req_valid && req_ready;
  assign w_push     = w_accept && w_in_range;

  // The gate is applied combinationally, so a closing gate stops pops in that
  // very cycle. A non-IDLE state guarantees at least one queued entry.
  assign w_pop      = (r_state != S_IDLE) && w_gate && !flush;

  // When a push and a pop happen together, they cancel and the level is unchanged.
  assign w_level_nxt = r_level + 5'(w_push) - 5'(w_pop);

  // Gate selection from the drain mode and the VGA blanking inputs.
  always_comb begin
    // NOTE: assign a default before the case so every path drives w_gate; a missing assignment would infer a latch.
    w_gate = 1'b0;
    case (w_mode)
      MODE_IMMEDIATE: w_gate = 1'b1;
      MODE_ANY_BLANK: w_gate = blank;
      MODE_VBLANK:    w_gate = vblank;
      MODE_HOLD:      w_gate = 1'b0;
      default:        w_gate = 1'b0;
    endcase
  end

  // Next scheduler state from the upcoming occupancy and the current gate.
  always_comb begin
    w_state_nxt = S_IDLE;
    if (flush || (w_level_nxt == 5'd0)) begin
      w_state_nxt = S_IDLE;
    end else if (w_gate) begin
      w_state_nxt = S_DRAIN;
    end else begin
      w_state_nxt = S_WAIT;
    end
  end

  // Queue storage is written on an in-range accept only.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; the pointers and level alone decide which entries are live.
    if (w_push) begin
      r_mem[r_wr_ptr] <= '{word: req_word, data: req_data};
    end
  end

  // Scheduler FSM, pointers, VRAM write port and sticky status flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_run       <= 1'b0;
      r_state     <= S_IDLE;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_vram_we   <= 1'b0;
      r_vram_word <= '0;
      r_vram_data <= '0;
      r_overflow  <= 1'b0;
      r_bad_addr  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments, so every right-hand side reads pre-edge values.
      r_run   <= 1'b1;
      r_state <= w_state_nxt;

      if (flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_level  <= '0;
      end else begin
        // Power-of-two depth, so pointers wrap naturally at DEPTH.
        if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
        r_level <= w_level_nxt;
      end

      // The strobe lasts one cycle; word and data hold their last values between writes.
      r_vram_we <= w_pop;
      if (w_pop) begin
        r_vram_word <= r_mem[r_rd_ptr].word;
        r_vram_data <= r_mem[r_rd_ptr].data;
      end

      // If a set event and clear_status arrive together, the set wins.
      if (req_valid && !req_ready) begin
        r_overflow <= 1'b1;
      end else if (clear_status) begin
        r_overflow <= 1'b0;
      end

      if (w_accept && !w_in_range) begin
        r_bad_addr <= 1'b1;
      end else if (clear_status) begin
        r_bad_addr <= 1'b0;
      end
    end
  end

  assign vram_we   = r_vram_we;
  assign vram_word = r_vram_word;
  assign vram_data = r_vram_data;
  assign level     = r_level;
  assign overflow  = r_overflow;
  assign bad_addr  = r_bad_addr;
  assign idle      = (r_level == 5'd0) && !r_vram_we;

  // Structural invariants: occupancy stays bounded, and IDLE means empty.
  a_level_bound: assert property (@(posedge clk) disable iff (!rst_n)
    r_level <= LP_DEPTH);
  a_idle_empty: assert property (@(posedge clk) disable iff (!rst_n)
    (r_state == S_IDLE) == (r_level == 5'd0));

endmodule

// File: tb/tb_vga_vram_write_scheduler.sv
`timescale 1ns/1ps
// Self-checking bench for vga_vram_write_scheduler.
// The stimulus pushes each expected VRAM write onto a scoreboard queue. An
// independent monitor pops one entry per observed vram_we strobe. Directed
// checks cover occupancy, latency, flags, flush and reset.
module tb_vga_vram_write_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_word;
  logic [31:0] req_data;
  logic [1:0]  mode;
  logic        blank;
  logic        vblank;
  logic        flush;
  logic        clear_status;
  logic        vram_we;
  logic [3:0]  vram_word;
  logic [31:0] vram_data;
  logic [4:0]  level;
  logic        overflow;
  logic        bad_addr;
  logic        idle;

  always #5 clk = ~clk;

  vga_vram_write_scheduler #(.DEPTH(4), .WORDS(10)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_word     (req_word),
    .req_data     (req_data),
    .mode         (mode),
    .blank        (blank),
    .vblank       (vblank),
    .flush        (flush),
    .clear_status (clear_status),
    .vram_we      (vram_we),
    .vram_word    (vram_word),
    .vram_data    (vram_data),
    .level        (level),
    .overflow     (overflow),
    .bad_addr     (bad_addr),
    .idle         (idle)
  );

  typedef struct packed {
    logic [3:0]  word;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;
  bit   mon_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Move to just after the next rising edge, where inputs are driven.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Present one request for one cycle; record its write if it should be enqueued.
  task automatic push(input logic [3:0] w, input logic [31:0] d, input bit enq);
    req_valid = 1'b1;
    req_word  = w;
    req_data  = d;
    if (enq) exp_q.push_back('{word: w, data: d});
    next_cycle();
    req_valid = 1'b0;
  endtask

  // Scoreboard monitor: every strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (mon_en && (vram_we !== 1'b0)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", 32'(vram_we), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("write_word", 32'(vram_word), 32'(mon_e.word));
        check("write_data", vram_data, mon_e.data);
      end
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_word = '0; req_data = '0;
    mode = 2'b00; blank = 1'b0; vblank = 1'b0; flush = 1'b0; clear_status = 1'b0;

    // Reset state
    repeat (2) next_cycle();
    @(negedge clk);
    check("rst_level", 32'(level), 32'd0);
    check("rst_we", 32'(vram_we), 32'd0);
    check("rst_word", 32'(vram_word), 32'd0);
    check("rst_data", vram_data, 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_bad_addr", 32'(bad_addr), 32'd0);
    check("rst_idle", 32'(idle), 32'd1);
    check("rst_ready", 32'(req_ready), 32'd0);
    mon_en = 1'b1;
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_release_cycle", 32'(req_ready), 32'd0);
    next_cycle();
    @(negedge clk);
    check("ready_after_release", 32'(req_ready), 32'd1);
    next_cycle();

    // Immediate mode: 2-cycle accept-to-write latency
    mode = 2'b00;
    push(4'd3, 32'hDEADBEEF, 1'b1);
    @(negedge clk);
    check("t1_level_after_accept", 32'(level), 32'd1);
    check("t1_no_we_yet", 32'(vram_we), 32'd0);
    next_cycle();
    @(negedge clk);
    check("t1_we_latency2", 32'(vram_we), 32'd1);
    check("t1_level_drained", 32'(level), 32'd0);
    next_cycle();
    @(negedge clk);
    check("t1_we_low", 32'(vram_we), 32'd0);
    check("t1_idle", 32'(idle), 32'd1);
    check("t1_word_hold", 32'(vram_word), 32'd3);
    check("t1_data_hold", vram_data, 32'hDEADBEEF);
    next_cycle();

    // Any-blank mode: fill to 4 with blank low, overflow, then burst
    mode = 2'b01;
    blank = 1'b0;
    push(4'd0, 32'h1111_0000, 1'b1);
    push(4'd1, 32'h2222_0001, 1'b1);
    push(4'd2, 32'h3333_0002, 1'b1);
    push(4'd9, 32'h4444_0009, 1'b1);
    @(negedge clk);
    check("t2_level_full", 32'(level), 32'd4);
    check("t2_ready_full", 32'(req_ready), 32'd0);
    check("t2_no_we_gated", 32'(vram_we), 32'd0);
    push(4'd5, 32'h5555_0005, 1'b0);
    @(negedge clk);
    check("t3_overflow_set", 32'(overflow), 32'd1);
    check("t3_level_stays", 32'(level), 32'd4);
    clear_status = 1'b1;
    next_cycle();
    clear_status = 1'b0;
    @(negedge clk);
    check("t3_overflow_cleared", 32'(overflow), 32'd0);
    check("t3_still_waiting", 32'(vram_we), 32'd0);
    blank = 1'b1;
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      @(negedge clk);
      check("t2_burst_we", 32'(vram_we), 32'd1);
    end
    next_cycle();
    @(negedge clk);
    check("t2_burst_end_we", 32'(vram_we), 32'd0);
    check("t2_idle", 32'(idle), 32'd1);
    check("t2_sb_empty", 32'(exp_q.size()), 32'd0);
    blank = 1'b0;

    // Out-of-range word index, and set-wins-over-clear
    mode = 2'b00;
    next_cycle();
    push(4'd10, 32'hBAD0_000A, 1'b0);
    @(negedge clk);
    check("t4_bad_addr_set", 32'(bad_addr), 32'd1);
    check("t4_level_unchanged", 32'(level), 32'd0);
    next_cycle();
    @(negedge clk);
    check("t4_no_we", 32'(vram_we), 32'd0);
    check("t4_idle", 32'(idle), 32'd1);
    clear_status = 1'b1;
    push(4'd15, 32'h0000_000F, 1'b0);
    clear_status = 1'b0;
    @(negedge clk);
    check("t4_set_wins_clear", 32'(bad_addr), 32'd1);
    clear_status = 1'b1;
    next_cycle();
    clear_status = 1'b0;
    @(negedge clk);
    check("t4_bad_addr_cleared", 32'(bad_addr), 32'd0);
    next_cycle();

    // Vblank-only mode: blank alone must not drain; 2 vblank cycles give 2 writes
    mode = 2'b10;
    blank = 1'b1;
    vblank = 1'b0;
    push(4'd4, 32'hA0A0_0004, 1'b1);
    push(4'd5, 32'hB0B0_0005, 1'b1);
    push(4'd6, 32'hC0C0_0006, 1'b1);
    @(negedge clk);
    check("t5_level3", 32'(level), 32'd3);
    check("t5_blank_ignored", 32'(vram_we), 32'd0);
    vblank = 1'b1;
    next_cycle();
    next_cycle();
    vblank = 1'b0;
    @(negedge clk);
    check("t5_second_write", 32'(vram_we), 32'd1);
    next_cycle();
    @(negedge clk);
    check("t5_stopped", 32'(vram_we), 32'd0);
    check("t5_level1", 32'(level), 32'd1);
    check("t5_sb_one_left", 32'(exp_q.size()), 32'd1);
    flush = 1'b1;
    exp_q.delete();
    #1;
    check("t5_ready_during_flush", 32'(req_ready), 32'd0);
    next_cycle();
    flush = 1'b0;
    @(negedge clk);
    check("t5_flush_level", 32'(level), 32'd0);
    check("t5_flush_idle", 32'(idle), 32'd1);
    blank = 1'b0;
    next_cycle();

    // Reset in the middle of a burst, asserted during the 2nd write
    mode = 2'b01;
    blank = 1'b0;
    push(4'd7, 32'h7777_0007, 1'b1);
    push(4'd8, 32'h8888_0008, 1'b1);
    push(4'd0, 32'h9999_0000, 1'b1);
    push(4'd1, 32'hAAAA_0001, 1'b1);
    @(negedge clk);
    check("t6_level_full", 32'(level), 32'd4);
    blank = 1'b1;
    next_cycle();
    @(negedge clk);
    check("t6_first_write", 32'(vram_we), 32'd1);
    next_cycle();
    rst_n = 1'b0;
    void'(exp_q.pop_back());
    void'(exp_q.pop_back());
    @(negedge clk);
    check("t6_second_write", 32'(vram_we), 32'd1);
    next_cycle();
    @(negedge clk);
    check("t6_reset_we", 32'(vram_we), 32'd0);
    check("t6_reset_level", 32'(level), 32'd0);
    check("t6_reset_ready", 32'(req_ready), 32'd0);
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_ready_release_cycle", 32'(req_ready), 32'd0);
    next_cycle();
    @(negedge clk);
    check("t6_ready_after_release", 32'(req_ready), 32'd1);
    check("t6_level_after_release", 32'(level), 32'd0);
    check("t6_idle_after_release", 32'(idle), 32'd1);
    repeat (4) next_cycle();
    blank = 1'b0;

    check("final_sb_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
